// File: rtl/cs_scan_arbiter_if.sv
// Requester-side bus of the colour-sensor scan arbiter: request/grant handshake
// plus the scan result registers.
interface cs_scan_arbiter_if #(
    parameter int unsigned CNT_W = 16
);
    logic [1:0]       req;
    logic [1:0]       grant;
    logic             busy;
    logic             done;
    logic [1:0]       color;
    logic [CNT_W-1:0] red_cnt;
    logic [CNT_W-1:0] green_cnt;
    logic [CNT_W-1:0] blue_cnt;

    modport master (
        output req,
        input  grant, busy, done, color, red_cnt, green_cnt, blue_cnt
    );

    modport slave (
        input  req,
        output grant, busy, done, color, red_cnt, green_cnt, blue_cnt
    );
endinterface

// File: rtl/cs_scan_arbiter.sv
// Round-robin scheduler sharing one TCS-style colour sensor between two requesters;
// each scan counts cs_out edges under green, red, blue filters and decides a colour.
// Optional macro CS_SETTLE_EN discards edges in the first 4 cycles of each window.
module cs_scan_arbiter #(
    parameter int unsigned WINDOW_US = 500,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned MIN_CNT   = 4
) (
    input  logic             clk_1MHz,
    input  logic             reset,
    input  logic             cs_out,
    output logic [1:0]       filter,
    cs_scan_arbiter_if.slave bus
);
    localparam int unsigned TMR_W = (WINDOW_US > 1) ? $clog2(WINDOW_US) : 1;

    localparam logic [1:0] F_RED   = 2'd0;
    localparam logic [1:0] F_BLUE  = 2'd1;
    localparam logic [1:0] F_CLEAR = 2'd2;
    localparam logic [1:0] F_GREEN = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRN,
        S_RED,
        S_BLU,
        S_DECIDE
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               rr_q, rr_d;
    logic [1:0]         grant_q, grant_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [1:0]         filter_q, filter_d;
    logic [1:0]         color_q, color_d;
    logic [CNT_W-1:0]   g_q, g_d, r_q, r_d, b_q, b_d;
    logic [CNT_W-1:0]   red_cnt_q, red_cnt_d;
    logic [CNT_W-1:0]   green_cnt_q, green_cnt_d;
    logic [CNT_W-1:0]   blue_cnt_q, blue_cnt_d;
    logic               meta_q, sync_q, prev_q;

    logic               edge_c;
    logic               cnt_en_c;
    logic               abort_c;
    logic               win_end_c;
    logic [TMR_W-1:0]   reload_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
    endfunction

    // Largest count wins, ties go red > green > blue; weak light means no object.
    function automatic logic [1:0] pick_color(input logic [CNT_W-1:0] r,
                                              input logic [CNT_W-1:0] g,
                                              input logic [CNT_W-1:0] b);
        logic [CNT_W-1:0] m;
        logic [1:0]       c;
        if (r >= g && r >= b) begin
            m = r;
            c = 2'd1;
        end else if (g >= b) begin
            m = g;
            c = 2'd2;
        end else begin
            m = b;
            c = 2'd3;
        end
        if (m < CNT_W'(MIN_CNT)) c = 2'd0;
        return c;
    endfunction

    assign edge_c    = sync_q & ~prev_q;
    assign abort_c   = ~|(bus.req & grant_q);
    assign win_end_c = (timer_q == '0);
    assign reload_c  = TMR_W'(WINDOW_US - 1);

`ifdef CS_SETTLE_EN
    // Timer counts down from WINDOW_US-1, so the first 4 window cycles sit above WINDOW_US-5.
    assign cnt_en_c = edge_c && (timer_q <= TMR_W'(WINDOW_US - 5));
`else
    assign cnt_en_c = edge_c;
`endif

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        done_d      = 1'b0;
        color_d     = color_q;
        g_d         = g_q;
        r_d         = r_q;
        b_d         = b_q;
        red_cnt_d   = red_cnt_q;
        green_cnt_d = green_cnt_q;
        blue_cnt_d  = blue_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    state_d = S_GRN;
                    timer_d = reload_c;
                    g_d     = '0;
                    if (&bus.req) begin
                        grant_d = rr_q ? 2'b10 : 2'b01;
                        rr_d    = ~rr_q;
                    end else begin
                        grant_d = bus.req;
                    end
                end
            end
            S_GRN: begin
                if (abort_c) begin
                    state_d = S_IDLE;
                end else begin
                    g_d     = sat_inc(g_q, cnt_en_c);
                    timer_d = timer_q - TMR_W'(1);
                    if (win_end_c) begin
                        state_d = S_RED;
                        timer_d = reload_c;
                        r_d     = '0;
                    end
                end
            end
            S_RED: begin
                if (abort_c) begin
                    state_d = S_IDLE;
                end else begin
                    r_d     = sat_inc(r_q, cnt_en_c);
                    timer_d = timer_q - TMR_W'(1);
                    if (win_end_c) begin
                        state_d = S_BLU;
                        timer_d = reload_c;
                        b_d     = '0;
                    end
                end
            end
            S_BLU: begin
                if (abort_c) begin
                    state_d = S_IDLE;
                end else begin
                    b_d     = sat_inc(b_q, cnt_en_c);
                    timer_d = timer_q - TMR_W'(1);
                    if (win_end_c) begin
                        state_d     = S_DECIDE;
                        red_cnt_d   = r_q;
                        green_cnt_d = g_q;
                        blue_cnt_d  = b_d;
                        color_d     = pick_color(r_q, g_q, b_d);
                        done_d      = 1'b1;
                    end
                end
            end
            S_DECIDE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_IDLE) grant_d = '0;
        busy_d = (state_d != S_IDLE);

        case (state_d)
            S_GRN:   filter_d = F_GREEN;
            S_RED:   filter_d = F_RED;
            S_BLU:   filter_d = F_BLUE;
            default: filter_d = F_CLEAR;
        endcase
    end

    always_ff @(posedge clk_1MHz or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            rr_q        <= 1'b0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            filter_q    <= F_CLEAR;
            color_q     <= '0;
            g_q         <= '0;
            r_q         <= '0;
            b_q         <= '0;
            red_cnt_q   <= '0;
            green_cnt_q <= '0;
            blue_cnt_q  <= '0;
            meta_q      <= 1'b0;
            sync_q      <= 1'b0;
            prev_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            filter_q    <= filter_d;
            color_q     <= color_d;
            g_q         <= g_d;
            r_q         <= r_d;
            b_q         <= b_d;
            red_cnt_q   <= red_cnt_d;
            green_cnt_q <= green_cnt_d;
            blue_cnt_q  <= blue_cnt_d;
            meta_q      <= cs_out;
            sync_q      <= meta_q;
            prev_q      <= sync_q;
        end
    end

    assign filter        = filter_q;
    assign bus.grant     = grant_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.color     = color_q;
    assign bus.red_cnt   = red_cnt_q;
    assign bus.green_cnt = green_cnt_q;
    assign bus.blue_cnt  = blue_cnt_q;
endmodule

// File: doc/cs_scan_arbiter.md
Name: cs_scan_arbiter

Overview:
- Scheduler for the colour-sensor frequency-detection path.
- Shares one TCS-style sensor (filter select + cs_out frequency output) between two requesters using round-robin request/grant.
- For each granted requester it runs one scan:
  - drives the filter sequence green, then red, then blue;
  - counts cs_out rising edges in a fixed window per filter;
  - returns the three counts and a colour decision with a one-cycle done pulse.

Parameters:
WINDOW_US, 500, clk_1MHz cycles per filter window (≥8)
CNT_W, 16, width of each edge counter
MIN_CNT, 4, winning count below this gives color=0 (no object)

Ports:
clk_1MHz  input  1  system clock, 1 MHz
reset  input  1  asynchronous active-high reset
cs_out  input  1  sensor frequency output, asynchronous to clk_1MHz, max frequency clk/4
req  input  2  scan request per requester, level, held until done
grant  output  2  one-hot grant, held for the whole scan
filter  output  2  sensor S2S3 select: 0 red, 1 blue, 2 clear, 3 green
busy  output  1  scan in progress
done  output  1  one-cycle pulse, results valid
color  output  2  0 none, 1 red, 2 green, 3 blue
red_cnt  output  CNT_W  red window edge count
green_cnt  output  CNT_W  green window edge count
blue_cnt  output  CNT_W  blue window edge count

Behaviour:
- Reset values (asynchronous):
  - state=IDLE, grant=0, filter=2, busy=0, done=0, color=0;
  - all *_cnt=0, rr pointer=requester 0.
- cs_out path: 2-flop synchronizer, then rising-edge detect. One count per detected edge.
- Counter rules:
  - counters clear on window entry;
  - counters saturate at 2^CNT_W-1 (no wrap).
- State machine:
  - IDLE: filter=2. If any req bit is set at a clock edge, move to GRN on that edge.
  - Grant selection: grant is registered. With a single request, that requester wins. With both bits set, the rr pointer requester wins and the pointer then toggles to the other requester.
  - GRN (filter=3), RED (filter=0), BLU (filter=1): each lasts exactly WINDOW_US cycles, tracked by a window timer that reloads on every state change.
  - DECIDE: lasts 1 cycle.
    - Latch the three counts into the outputs.
    - Set color.
    - Assert done=1.
    - Next state is IDLE. grant and busy drop on the following edge.
- Latency: first grant cycle to done = 3*WINDOW_US+1 cycles.
- Output timing: busy=1 and grant≠0 from the GRN entry edge through the DECIDE cycle inclusive.
- IDLE is held for at least 1 cycle between scans, even when req is still high.
- Colour decision:
  - max of red, green, blue counts;
  - ties resolve red > green > blue;
  - color=0 if the max count < MIN_CNT.
- Abort: if the granted req bit drops during GRN, RED or BLU:
  - return to IDLE next edge, no done;
  - result outputs keep their previous values;
  - the rr pointer still advances.
- Result hold: results are held stable between done pulses. The non-granted requester's req is ignored during a scan.
- Reset mid-scan: immediate return to reset values, no done.

Optional Feature:
- Macro: CS_SETTLE_EN.
- Defined: the first 4 cycles of each GRN, RED and BLU window are a settle interval. Edge detections in those cycles are discarded. Window length is unchanged, so effective count time is WINDOW_US-4.
- Undefined: every cycle of each window counts.
- Test plan values below assume the macro is undefined.

Test Plan:
- Reset assertion mid-BLU (cycle 1200 of a scan) -> all outputs return to reset values within the same cycle, no done, scan restarts from GRN if req is still held after release.
- req=01, cs_out period 10 cycles in red window and 20 cycles elsewhere (pattern switched on filter change), WINDOW_US=500 -> done after 1501 cycles, red_cnt=50±1, green_cnt=25±1, blue_cnt=25±1, color=1.
- req=10, green period 8 cycles, red and blue period 40 cycles -> grant=10 throughout, green_cnt=62±1, color=2. Filter sequence 2→3→0→1→2 observed with 500-cycle dwell each.
- req=11 held for three scans -> grants 01, 10, 01 in order. Each done is followed by ≥1 IDLE cycle with filter=2.
- cs_out constant 0 -> counts 0, color=0. Then req=01 dropped at cycle 700 -> return to IDLE, no done, prior results unchanged.
